// File: rtl/spi_frame_assembler.sv
// spi_frame_assembler: assemble SPI bytes into plaintext/key frames and stream the 128-bit AES result back out bytewise
module spi_frame_assembler #(
  parameter int NUM_PT_BYTES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [127:0] plain_text,
  output logic [255:0] key,
  output logic [7:0]   key_size,
  output logic         frame_valid,
  output logic         frame_error,
  input  logic [127:0] result,
  input  logic         result_valid,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ack,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {RX_PT, RX_SIZE, RX_KEY, WAIT_RES, TX_RES} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [127:0] pt_q, pt_d, sr_q, sr_d;
  logic [255:0] key_q, key_d;
  logic [7:0] ks_q, ks_d;
  logic tx_valid_q, tx_valid_d, fv_q, fv_d, fe_q, fe_d, done_q, done_d;
  logic [6:0] pt_lsb;
  logic [7:0] key_lsb;
  logic size_ok, last_pt, last_key, last_tx;
  // byte cnt lands at bits [8*(15-cnt) +: 8]; 15-cnt is just ~cnt for cnt < 16
  assign pt_lsb   = {~cnt_q[3:0], 3'b000};
  // key byte n lands at bits [8*(key_size-n-1) +: 8], right-aligned
  assign key_lsb  = {5'(ks_q[5:0] - cnt_q - 6'd1), 3'b000};
  assign size_ok  = rx_byte inside {8'd16, 8'd24, 8'd32};
  assign last_pt  = cnt_q == 6'(NUM_PT_BYTES - 1);
  assign last_key = {2'b00, cnt_q} == ks_q - 8'd1;
  assign last_tx  = cnt_q == 6'd15;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX_PT;
      cnt_q      <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      ks_q       <= '0;
      sr_q       <= '0;
      tx_valid_q <= 1'b0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      ks_q       <= ks_d;
      sr_q       <= sr_d;
      tx_valid_q <= tx_valid_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      done_q     <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_PT:    if (rx_valid && last_pt) state_d = RX_SIZE;
      RX_SIZE:  if (rx_valid) state_d = size_ok ? RX_KEY : RX_PT;
      RX_KEY:   if (rx_valid && last_key) state_d = WAIT_RES;
      WAIT_RES: if (result_valid) state_d = TX_RES;
      TX_RES:   if (tx_ack && tx_valid_q && last_tx) state_d = RX_PT;
      default:  state_d = RX_PT;
    endcase
  end
  always_comb begin
    cnt_d      = cnt_q;
    pt_d       = pt_q;
    key_d      = key_q;
    ks_d       = ks_q;
    sr_d       = sr_q;
    tx_valid_d = tx_valid_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      RX_PT: if (rx_valid) begin
        pt_d[pt_lsb +: 8] = rx_byte;
        cnt_d = last_pt ? '0 : cnt_q + 6'd1;
      end
      RX_SIZE: if (rx_valid) begin
        ks_d  = size_ok ? rx_byte : ks_q;
        key_d = size_ok ? '0 : key_q;
        fe_d  = !size_ok;
      end
      RX_KEY: if (rx_valid) begin
        key_d[key_lsb +: 8] = rx_byte;
        cnt_d = last_key ? '0 : cnt_q + 6'd1;
        fv_d  = last_key;
      end
      WAIT_RES: if (result_valid) begin
        sr_d       = result;
        tx_valid_d = 1'b1;
      end
      TX_RES: if (tx_ack && tx_valid_q) begin
        sr_d       = sr_q << 8;
        cnt_d      = last_tx ? '0 : cnt_q + 6'd1;
        tx_valid_d = !last_tx;
        done_d     = last_tx;
      end
      default: ;
    endcase
  end
  always_comb begin
    busy        = !(state_q == RX_PT && cnt_q == 6'd0);
    plain_text  = pt_q;
    key         = key_q;
    key_size    = ks_q;
    tx_byte     = sr_q[127:120];
    tx_valid    = tx_valid_q;
    frame_valid = fv_q;
    frame_error = fe_q;
    done        = done_q;
  end
endmodule

// File: tb/tb_spi_frame_assembler.sv
// tb_spi_frame_assembler: randomized self-checking bench against a byte-stream reference model
module tb_spi_frame_assembler;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] rx_byte = '0;
  logic rx_valid = 1'b0;
  logic [127:0] result = '0;
  logic result_valid = 1'b0, tx_ack = 1'b0;
  logic [127:0] plain_text;
  logic [255:0] key;
  logic [7:0] key_size, tx_byte;
  logic frame_valid, frame_error, tx_valid, busy, done;
  int checks = 0, errors = 0, fv_cnt = 0, fe_cnt = 0, done_cnt = 0;
  logic [7:0] pt_a [16];
  logic [7:0] kb_a [32];
  logic [127:0] pt_exp;
  logic [255:0] key_exp;
  spi_frame_assembler #(.NUM_PT_BYTES(16)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .plain_text(plain_text), .key(key), .key_size(key_size),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .result(result), .result_valid(result_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
    if (done === 1'b1) done_cnt++;
    if (frame_valid | frame_error | done) begin
      checks++;
      if ($countones({frame_valid, frame_error, done}) != 1) begin
        errors++;
        $display("FAIL exclusive_pulses got fv=%0b fe=%0b done=%0b want only one", frame_valid, frame_error, done);
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Sends pt_a, the size byte and kb_a; expected frame is built by appending bytes.
  task automatic run_frame(input logic [7:0] ks, input int gap, input bit rnoise);
    int fv0 = fv_cnt;
    pt_exp  = '0;
    key_exp = '0;
    for (int i = 0; i < 16; i++) begin
      pt_exp = {pt_exp[119:0], pt_a[i]};
      send_byte(pt_a[i]);
      idle($urandom_range(0, gap));
    end
    send_byte(ks);
    idle($urandom_range(0, gap));
    for (int i = 0; i < int'(ks); i++) begin
      key_exp = {key_exp[247:0], kb_a[i]};
      if (rnoise) begin
        result = {$urandom, $urandom, $urandom, $urandom};
        result_valid = 1'b1;
      end
      send_byte(kb_a[i]);
      result_valid = 1'b0;
      if (i < int'(ks) - 1) idle($urandom_range(0, gap));
    end
    checks++;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL frame_valid_rise got %0b want 1", frame_valid); end
    checks++;
    if (plain_text !== pt_exp) begin errors++; $display("FAIL plain_text got %h want %h", plain_text, pt_exp); end
    checks++;
    if (key !== key_exp) begin errors++; $display("FAIL key got %h want %h", key, key_exp); end
    checks++;
    if (key_size !== ks) begin errors++; $display("FAIL key_size got %0d want %0d", key_size, ks); end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_res got tx_valid=%0b busy=%0b want 0/1", tx_valid, busy); end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0 || fv_cnt - fv0 != 1) begin errors++; $display("FAIL frame_valid_pulse got level=%0b pulses=%0d want 0/1", frame_valid, fv_cnt - fv0); end
  endtask
  // Delivers r, then acks each byte after a random delay; noise pulses rx_valid while waiting.
  task automatic run_tx(input logic [127:0] r, input int maxd, input bit noise);
    int d0 = done_cnt;
    logic [7:0] exp;
    result = r;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = 8'(r >> (8 * (15 - i)));
      repeat ($urandom_range(0, maxd)) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_byte !== exp) begin errors++; $display("FAIL tx_hold byte %0d got %h/%0b want %h/1", i, tx_byte, tx_valid, exp); end
        if (noise) begin rx_byte = 8'($urandom); rx_valid = 1'b1; end
        @(negedge clk);
        rx_valid = 1'b0;
      end
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp) begin errors++; $display("FAIL tx_byte %0d got %h/%0b want %h/1", i, tx_byte, tx_valid, exp); end
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL done_rise got done=%0b tx_valid=%0b want 1/0", done, tx_valid); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulse got done=%0b busy=%0b pulses=%0d want 0/0/1", done, busy, done_cnt - d0); end
  endtask
  task automatic load_seq(input logic [7:0] pt_step, input logic [7:0] key_step);
    for (int i = 0; i < 16; i++) pt_a[i] = 8'(i * pt_step);
    for (int i = 0; i < 32; i++) kb_a[i] = 8'(i * key_step);
  endtask
  task automatic load_rand();
    for (int i = 0; i < 16; i++) pt_a[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) kb_a[i] = 8'($urandom);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if (plain_text !== '0 || key !== '0 || key_size !== '0 || tx_byte !== '0) begin errors++; $display("FAIL reset_data got pt=%h ks=%h tx=%h want 0", plain_text, key_size, tx_byte); end
    checks++;
    if (tx_valid !== 1'b0 || frame_valid !== 1'b0 || frame_error !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b%0b%0b want 0000", tx_valid, frame_valid, frame_error, done); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stray_ack got busy=%0b tx_valid=%0b done=%0b want 000", busy, tx_valid, done); end
  endtask
  task automatic test_aes256();
    load_seq(8'h11, 8'h01);
    run_frame(8'd32, 0, 1'b0);
    checks++;
    if (pt_exp !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL aes256_model got %h", pt_exp); end
  endtask
  task automatic test_result_tx();
    run_tx(128'h8ea2b7ca516745bfeafc49904b496089, 5, 1'b0);
  endtask
  task automatic test_aes128();
    load_seq(8'h11, 8'h01);
    run_frame(8'd16, 1, 1'b0);
    checks++;
    if (key[255:128] !== '0 || key[127:0] !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL aes128_key got %h", key); end
    run_tx({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0);
  endtask
  task automatic test_illegal_size();
    int fe0 = fe_cnt;
    load_rand();
    for (int i = 0; i < 16; i++) send_byte(pt_a[i]);
    send_byte(8'h11);
    checks++;
    if (frame_error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_size got fe=%0b busy=%0b want 1/0", frame_error, busy); end
    @(negedge clk);
    checks++;
    if (frame_error !== 1'b0 || fe_cnt - fe0 != 1) begin errors++; $display("FAIL illegal_pulse got fe=%0b pulses=%0d want 0/1", frame_error, fe_cnt - fe0); end
    load_rand();
    run_frame(8'd24, 1, 1'b0);
    run_tx({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0);
  endtask
  task automatic test_reset_mid();
    int fv0 = fv_cnt, d0;
    load_rand();
    for (int i = 0; i < 16; i++) send_byte(pt_a[i]);
    send_byte(8'd32);
    for (int i = 0; i < 10; i++) send_byte(kb_a[i]);
    reset = 1'b1;
    rx_byte = 8'haa;
    rx_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (plain_text !== '0 || key !== '0 || key_size !== '0 || frame_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_frame got pt=%h ks=%h fv=%0b want 0", plain_text, key_size, frame_valid); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %0b want 0", busy); end
    load_rand();
    run_frame(8'd32, 0, 1'b0);
    checks++;
    if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL aborted_frame pulses got %0d want 1", fv_cnt - fv0); end
    d0 = done_cnt;
    result = 128'hffeeddccbbaa99887766554433221100;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (3) begin tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    checks++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || busy !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL reset_mid_tx got tx=%h/%0b busy=%0b done=%0d want 00/0/0/%0d", tx_byte, tx_valid, busy, done_cnt, d0); end
  endtask
  task automatic test_ignored();
    load_rand();
    run_frame(8'd24, 1, 1'b1);
    repeat (3) send_byte(8'($urandom));
    checks++;
    if (plain_text !== pt_exp || key !== key_exp || key_size !== 8'd24) begin errors++; $display("FAIL rx_in_wait got pt=%h ks=%0d want %h/24", plain_text, key_size, pt_exp); end
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL rx_in_wait_state got busy=%0b tx_valid=%0b want 1/0", busy, tx_valid); end
    run_tx({$urandom, $urandom, $urandom, $urandom}, 4, 1'b1);
    checks++;
    if (plain_text !== pt_exp || key !== key_exp || key_size !== 8'd24) begin errors++; $display("FAIL rx_in_tx got pt=%h ks=%0d want %h/24", plain_text, key_size, pt_exp); end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++) begin
      load_rand();
      run_frame(8'(16 + 8 * $urandom_range(0, 2)), n % 3, 1'b0);
      run_tx({$urandom, $urandom, $urandom, $urandom}, n, 1'b0);
    end
  endtask
  initial begin
    test_reset();
    test_aes256();
    test_result_tx();
    test_aes128();
    test_illegal_size();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
